// File: rtl/injection_queue.sv
// ---------------------------------------------------------------------------
// injection_queue
//
// Per-node injection buffer between a traffic source and the router's local
// input port. Packets strobed in by the source are held in a DEPTH-entry FIFO
// and presented to the router until accepted. Self-addressed packets are
// dropped as loopback. Packets arriving at a full queue are dropped as
// overflow. Both kinds of drop are counted.
//
// Parameters
//   id     node id; a packet whose destination field equals id is a loopback.
//          The default of -1 never matches a destination, so nothing is
//          treated as loopback.
//   DEPTH  number of FIFO entries; a power of two from 2 to 16.
//   CNT_W  width of the saturating statistics counters.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   in_data   packet from the source; [ADDR_SZ-1:0] = destination,
//             upper bits = payload
//   in_req    one-cycle strobe qualifying in_data
//   in_busy   backpressure to the source (asserted at count >= DEPTH-1)
//   out_data  head-of-queue packet
//   out_req   out_data is valid (queue not empty)
//   out_busy  router cannot accept this cycle
//   flush     synchronous clear of the queue contents
//   count     current occupancy, 0..DEPTH
//   sent_cnt  packets forwarded to the router
//   drop_cnt  packets dropped because the queue was full
//   loop_cnt  packets dropped as loopback
//   overflow  sticky; set by the first full-drop, cleared only by reset
//
// Handshake: out_req/out_busy is a hold-until-accepted valid/ready pair. A
// transfer happens at a rising edge where out_req=1 and out_busy=0. While
// out_busy=1, out_req and out_data stay stable. The source side has no
// acceptance: in_req is a one-cycle strobe. in_busy is only advisory, and
// the source reacts to it one cycle late.
// ---------------------------------------------------------------------------

`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module injection_queue #(
  parameter int id    = -1,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [`PAYLOAD_SIZE+`ADDR_SZ-1:0] in_data,
  input  logic                              in_req,
  output logic                              in_busy,
  output logic [`PAYLOAD_SIZE+`ADDR_SZ-1:0] out_data,
  output logic                              out_req,
  input  logic                              out_busy,
  input  logic                              flush,
  output logic [$clog2(DEPTH):0]            count,
  output logic [CNT_W-1:0]                  sent_cnt,
  output logic [CNT_W-1:0]                  drop_cnt,
  output logic [CNT_W-1:0]                  loop_cnt,
  output logic                              overflow
);

  localparam int DW = `PAYLOAD_SIZE + `ADDR_SZ;
  localparam int AW = `ADDR_SZ;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] BUSY_LVL = CW'(DEPTH - 1);

  // The id is compared as a 32-bit pattern. A negative id therefore never
  // equals a zero-extended destination field.
  localparam logic [31:0] ID_BITS = id;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic          is_loop;
  logic          req_live;
  logic          pop;
  logic          push_cand;
  logic          push;
  logic          full_drop;
  logic          loop_drop;

  // -------------------------------------------------------------------------
  // Event decode
  // -------------------------------------------------------------------------
  always_comb begin
    is_loop   = ({{(32-AW){1'b0}}, in_data[AW-1:0]} == ID_BITS);
    req_live  = in_req && !flush;
    pop       = out_req && !out_busy && !flush;
    push_cand = req_live && !is_loop;
    // A full queue still accepts a push when a pop frees a slot on the same
    // edge. The loopback check comes first, so a loopback packet is never
    // counted as a full-drop.
    push      = push_cand && ((count < FULL_LVL) || pop);
    full_drop = push_cand && !push;
    loop_drop = req_live && is_loop;
  end

  // -------------------------------------------------------------------------
  // Outputs, combinational from registered state
  // -------------------------------------------------------------------------
  always_comb begin
    out_req  = (count != '0);
    out_data = mem[rd_ptr];
    // One slot is held back because the source only sees busy a cycle late.
    in_busy  = (count >= BUSY_LVL);
  end

  // -------------------------------------------------------------------------
  // Storage; not reset, so stale entries simply become invisible
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // -------------------------------------------------------------------------
  // Pointers and occupancy
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so the natural rollover is the wrap.
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Saturating statistics and the sticky overflow flag. Flush does not touch
  // them; pop, full_drop and loop_drop are already gated off during flush.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sent_cnt <= '0;
      drop_cnt <= '0;
      loop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop && (sent_cnt != '1)) begin
        sent_cnt <= sent_cnt + 1'b1;
      end
      if (full_drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
      if (loop_drop && (loop_cnt != '1)) begin
        loop_cnt <= loop_cnt + 1'b1;
      end
      if (full_drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_injection_queue.sv
// ---------------------------------------------------------------------------
// tb_injection_queue
//
// Directed bench for injection_queue with id=0, DEPTH=4 and CNT_W=16.
// Each scenario task drives its own stimulus and compares outputs against
// hand-computed values. The running counter expectations carry over from
// one task to the next.
// ---------------------------------------------------------------------------

`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module tb_injection_queue;

  localparam int DW = `PAYLOAD_SIZE + `ADDR_SZ;

  // clock / reset / dut ------------------------------------------------------
  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_req;
  logic          in_busy;
  logic [DW-1:0] out_data;
  logic          out_req;
  logic          out_busy;
  logic          flush;
  logic [2:0]    count;
  logic [15:0]   sent_cnt;
  logic [15:0]   drop_cnt;
  logic [15:0]   loop_cnt;
  logic          overflow;

  always #5 clk = ~clk;

  injection_queue #(.id(0), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_req(in_req), .in_busy(in_busy),
    .out_data(out_data), .out_req(out_req), .out_busy(out_busy),
    .flush(flush), .count(count),
    .sent_cnt(sent_cnt), .drop_cnt(drop_cnt), .loop_cnt(loop_cnt),
    .overflow(overflow)
  );

  int total = 0;
  int bad   = 0;

  // Running expectations for the statistics.
  logic [15:0] exp_sent;
  logic [15:0] exp_drop;
  logic [15:0] exp_loop;
  logic        exp_ovf;

  logic [DW-1:0] exp_q[$];

  // driver helpers -----------------------------------------------------------
  // Every step advances one rising edge and then waits 1 time unit. Inputs
  // are driven and outputs sampled at that point, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pkt(input logic [7:0] pay, input logic [3:0] dst);
    return {pay, dst};
  endfunction

  task automatic push_one(input logic [DW-1:0] d);
    in_data = d;
    in_req  = 1'b1;
    step();
    in_req  = 1'b0;
  endtask

  task automatic check_stats(input string tag);
    total++;
    if (sent_cnt !== exp_sent) begin
      bad++; $display("FAIL %s_sent got=%0d want=%0d", tag, sent_cnt, exp_sent);
    end
    total++;
    if (drop_cnt !== exp_drop) begin
      bad++; $display("FAIL %s_drop got=%0d want=%0d", tag, drop_cnt, exp_drop);
    end
    total++;
    if (loop_cnt !== exp_loop) begin
      bad++; $display("FAIL %s_loop got=%0d want=%0d", tag, loop_cnt, exp_loop);
    end
    total++;
    if (overflow !== exp_ovf) begin
      bad++; $display("FAIL %s_ovf got=%0b want=%0b", tag, overflow, exp_ovf);
    end
  endtask

  // scenarios ----------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0; in_req = 1'b0; in_data = '0; out_busy = 1'b0; flush = 1'b0;
    #12;
    reset = 1'b1;
    step();
    exp_sent = 0; exp_drop = 0; exp_loop = 0; exp_ovf = 1'b0;
    total++;
    if (out_req !== 1'b0) begin bad++; $display("FAIL rst_out_req got=%0b want=0", out_req); end
    total++;
    if (in_busy !== 1'b0) begin bad++; $display("FAIL rst_in_busy got=%0b want=0", in_busy); end
    total++;
    if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
    check_stats("rst");
  endtask

  task automatic test_single();
    out_busy = 1'b0;
    push_one(pkt(8'h00, 4'd3));
    total++;
    if (out_req !== 1'b1) begin bad++; $display("FAIL single_req got=%0b want=1", out_req); end
    total++;
    if (out_data !== 12'h003) begin bad++; $display("FAIL single_data got=%h want=003", out_data); end
    total++;
    if (count !== 3'd1) begin bad++; $display("FAIL single_count1 got=%0d want=1", count); end
    step();
    exp_sent = 1;
    total++;
    if (count !== 3'd0) begin bad++; $display("FAIL single_count0 got=%0d want=0", count); end
    total++;
    if (out_req !== 1'b0) begin bad++; $display("FAIL single_req0 got=%0b want=0", out_req); end
    check_stats("single");
  endtask

  task automatic test_fill_stall();
    out_busy = 1'b1;
    exp_q = {};
    for (int i = 1; i <= 3; i++) begin
      push_one(pkt(8'(8'h10 * i + i), 4'(i)));
      exp_q.push_back(pkt(8'(8'h10 * i + i), 4'(i)));
      if (i == 2) begin
        total++;
        if (in_busy !== 1'b0) begin bad++; $display("FAIL fill_busy_at2 got=%0b want=0", in_busy); end
      end
      step();  // source paces itself to one push every other cycle
    end
    total++;
    if (count !== 3'd3) begin bad++; $display("FAIL fill_count got=%0d want=3", count); end
    total++;
    if (in_busy !== 1'b1) begin bad++; $display("FAIL fill_busy got=%0b want=1", in_busy); end
    step(); step();
    total++;
    if (count !== 3'd3) begin bad++; $display("FAIL fill_hold got=%0d want=3", count); end
    total++;
    if (out_data !== exp_q[0]) begin bad++; $display("FAIL fill_head got=%h want=%h", out_data, exp_q[0]); end
    check_stats("fill_hold");
    out_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_req !== 1'b1 || out_data !== exp_q[0]) begin
        bad++; $display("FAIL fill_pop%0d got=%h req=%0b want=%h", i, out_data, out_req, exp_q[0]);
      end
      void'(exp_q.pop_front());
      step();
      exp_sent++;
    end
    total++;
    if (count !== 3'd0) begin bad++; $display("FAIL fill_empty got=%0d want=0", count); end
    check_stats("fill_drain");
  endtask

  task automatic test_overflow();
    out_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = pkt(8'(8'hA0 + i), 4'(1 + (i % 3)));
      in_req  = 1'b1;
      step();
    end
    in_req = 1'b0;
    exp_drop = 1; exp_ovf = 1'b1;
    total++;
    if (count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d want=4", count); end
    total++;
    if (out_data !== pkt(8'hA0, 4'd1)) begin bad++; $display("FAIL ovf_head got=%h want=a01", out_data); end
    check_stats("ovf");
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++;
    if (count !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d want=0", count); end
    total++;
    if (out_req !== 1'b0) begin bad++; $display("FAIL flush_req got=%0b want=0", out_req); end
    check_stats("flush");
  endtask

  task automatic test_loopback();
    out_busy = 1'b0;
    push_one(pkt(8'h5A, 4'd0));
    exp_loop = 1;
    total++;
    if (count !== 3'd0) begin bad++; $display("FAIL loop_count got=%0d want=0", count); end
    total++;
    if (out_req !== 1'b0) begin bad++; $display("FAIL loop_req got=%0b want=0", out_req); end
    check_stats("loop");
  endtask

  task automatic test_push_pop_full();
    out_busy = 1'b1;
    exp_q = {};
    for (int i = 0; i < 4; i++) begin
      push_one(pkt(8'(8'hC0 + i), 4'(1 + i % 3)));
      exp_q.push_back(pkt(8'(8'hC0 + i), 4'(1 + i % 3)));
    end
    total++;
    if (count !== 3'd4) begin bad++; $display("FAIL pp_full got=%0d want=4", count); end
    out_busy = 1'b0;
    push_one(pkt(8'hC4, 4'd2));
    exp_q.push_back(pkt(8'hC4, 4'd2));
    void'(exp_q.pop_front());
    exp_sent++;
    total++;
    if (count !== 3'd4) begin bad++; $display("FAIL pp_count got=%0d want=4", count); end
    check_stats("pp");
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_req !== 1'b1 || out_data !== exp_q[0]) begin
        bad++; $display("FAIL pp_order%0d got=%h req=%0b want=%h", i, out_data, out_req, exp_q[0]);
      end
      void'(exp_q.pop_front());
      step();
      exp_sent++;
    end
    total++;
    if (count !== 3'd0) begin bad++; $display("FAIL pp_empty got=%0d want=0", count); end
    check_stats("pp_drain");
  endtask

  task automatic test_async_reset();
    out_busy = 1'b1;
    push_one(pkt(8'hE1, 4'd1));
    push_one(pkt(8'hE2, 4'd2));
    total++;
    if (count !== 3'd2) begin bad++; $display("FAIL ar_pre got=%0d want=2", count); end
    #2;
    reset = 1'b0;   // mid-cycle, no clock edge in between
    #1;
    exp_sent = 0; exp_drop = 0; exp_loop = 0; exp_ovf = 1'b0;
    total++;
    if (out_req !== 1'b0) begin bad++; $display("FAIL ar_req got=%0b want=0", out_req); end
    total++;
    if (count !== 3'd0) begin bad++; $display("FAIL ar_count got=%0d want=0", count); end
    total++;
    if (in_busy !== 1'b0) begin bad++; $display("FAIL ar_busy got=%0b want=0", in_busy); end
    check_stats("ar");
    #2;
    reset = 1'b1;
    out_busy = 1'b0;
    step();
    push_one(pkt(8'h77, 4'd3));
    total++;
    if (out_req !== 1'b1 || out_data !== pkt(8'h77, 4'd3)) begin
      bad++; $display("FAIL ar_after got=%h req=%0b want=773", out_data, out_req);
    end
    step();
    exp_sent = 1;
    check_stats("ar_after");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_stall();
    test_overflow();
    test_loopback();
    test_push_pop_full();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/injection_queue.md
# injection_queue

Per-node injection buffer between the traffic source and the router's local input port. It captures each packet the source emits and holds it in a DEPTH-entry FIFO. It presents packets to the router under a hold-until-accepted handshake and backpressures the source through the source's busy input. Self-addressed and overflowing packets are dropped and counted.

## Interface
- id, -1, node id; packets whose address field equals id are dropped as loopback.
- DEPTH, 4, FIFO entries; power of two, 2..16.
- CNT_W, 16, width of the statistics counters.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_data  in  `PAYLOAD_SIZE+`ADDR_SZ  packet from the source.
  - Bits [`ADDR_SZ-1:0] are the destination; the upper bits are the payload.
- in_req  in  1  one-cycle strobe; in_data is valid in that cycle.
- in_busy  out  1  backpressure to the source's busy input.
- out_data  out  `PAYLOAD_SIZE+`ADDR_SZ  head-of-queue packet to the router.
- out_req  out  1  out_data is valid.
- out_busy  in  1  router cannot accept this cycle.
- flush  in  1  synchronous clear of queue contents.
- count  out  $clog2(DEPTH)+1  current occupancy.
- sent_cnt / drop_cnt / loop_cnt  out  CNT_W each  packets forwarded / dropped on full / dropped as loopback.
- overflow  out  1  sticky flag; set on the first full-drop.

## Operation
- Storage:
  - mem[DEPTH] with wr_ptr and rd_ptr, each $clog2(DEPTH) bits.
  - Pointers wrap modulo DEPTH.
  - count ranges 0..DEPTH.
- Push condition: in_req=1, flush=0, and in_data[`ADDR_SZ-1:0] != id.
  - If count<DEPTH, or a pop occurs in the same cycle: write mem[wr_ptr] and increment wr_ptr.
  - Otherwise drop the packet, increment drop_cnt and set overflow.
- Loopback: when in_req=1, flush=0 and the destination equals id, increment loop_cnt.
  - Nothing is written.
  - This check is made before the full check, so a loopback packet never counts as a full-drop.
- Pop: out_req=1 and out_busy=0 at the clock edge. rd_ptr increments and sent_cnt increments.
- Outputs:
  - out_req = (count != 0).
  - out_data = mem[rd_ptr].
  - Both are combinational from registered state.
  - out_data is held stable while out_busy=1.
- in_busy = (count >= DEPTH-1).
  - The source registers its req one cycle after sampling busy, so one slot of skid is reserved.
  - In normal operation no full-drop occurs.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - This applies at count=DEPTH as well: a push into a full queue succeeds when a pop happens in the same cycle.
- flush=1:
  - wr_ptr, rd_ptr and count are cleared.
  - No push or pop happens that cycle.
  - No counters change.
  - overflow is retained.
- Statistics counters saturate at 2^CNT_W-1; they do not wrap.
- Reset (reset=0, any time, asynchronous):
  - Pointers, count, all counters and overflow go to 0.
  - Outputs follow: out_req=0, in_busy=0.
  - out_data is don't-care; mem is not cleared.
  - Reset mid-transfer discards all queued packets.

## Timing
- Latency: in_req in cycle N gives out_req=1 with that packet in cycle N+1 (empty queue, no flush).
- Throughput:
  - One pop per cycle.
  - One push per cycle is accepted. The source itself issues at most one push every 2 cycles.
- in_busy updates in the cycle after the push or pop that changes count.
- Ordering: strict FIFO; no reordering and no duplication.
- Release of reset is asynchronous-assert / synchronous-deassert safe: the first active edge after reset rises is a normal cycle.

## Test plan
- Reset state: reset=0 then release. Required: out_req=0, in_busy=0, count=0, all counters 0, overflow=0.
- Single packet, id=0, DEPTH=4:
  - Stimulus: in_data={payload 0, dest 3}, in_req for 1 cycle, out_busy=0.
  - Required: out_req=1 next cycle with the same data; after the following edge, count=0 and sent_cnt=1.
- Fill with stall:
  - Stimulus: out_busy=1, source pattern of pushes with dest 1,2,3.
  - Required: count reaches 3 and in_busy=1, holding at 3 with no drops.
  - Then release out_busy. Required: dests pop in order 1,2,3 on consecutive cycles, sent_cnt=3.
- Forced overflow:
  - Stimulus: out_busy=1, in_req every cycle, 5 packets ignoring in_busy.
  - Required: count=4, drop_cnt=1, overflow=1.
  - Then flush for 1 cycle. Required: count=0, overflow stays 1.
- Loopback: push a packet with dest=id=0. Required: loop_cnt=1, count stays 0, out_req stays 0.
- Simultaneous push and pop at full:
  - Stimulus: count=4, out_busy=0 and in_req in the same cycle.
  - Required: count stays 4, drop_cnt unchanged, the new packet emerges after the 3 older ones.
- Async reset mid-stream: assert reset between edges with count=2. Required: out_req=0 and count=0 immediately, without waiting for a clock edge.
